// File: rtl/booth_arbiter.sv
// booth_arbiter: round-robin front end that shares one algoritm_booth
// multiplier among N requesters. It latches the winner's operands, holds
// the multiplier enable for the full Booth sequence, then returns the
// captured product with a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | multiplier disabled; arbitrate among qualified requests
// RUN   | multiplier enabled; count START + WIDTH RUN/SHIFT pairs + RESULT
// DONE  | multiplier disabled, its result valid; capture, pulse done, release

module booth_arbiter #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   mpd_in,
  input  logic [N*WIDTH-1:0]   mpr_in,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 mul_enable,
  output logic [WIDTH-1:0]     mul_mpd,
  output logic [WIDTH-1:0]     mul_mpr,
  input  logic [2*WIDTH-1:0]   mul_res
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(2*WIDTH + 2);
  // Last RUN cycle: enable has then been high for 2*WIDTH+2 edges in total.
  localparam logic [CW-1:0] LAST_CNT = CW'(2*WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       ptr, ptr_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [N-1:0]        gnt_nxt, done_nxt;
  logic [2*WIDTH-1:0]  result_nxt;
  logic [WIDTH-1:0]    mpd_nxt, mpr_nxt;

  logic [N-1:0]        req_qual;
  logic                sel_valid;
  logic [IW-1:0]       sel_idx;

  // A requester is not eligible in the cycle its done pulse is out, so a
  // client that has not yet dropped req is not immediately granted again.
  assign req_qual = req & ~done;

  // Round-robin pick: first qualified requester at or after the pointer.
  always_comb begin
    int            j;
    logic [IW-1:0] j_idx;
    sel_valid = 1'b0;
    sel_idx   = '0;
    j         = 0;
    j_idx     = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      j_idx = IW'(j);
      if (!sel_valid && req_qual[j_idx]) begin
        sel_valid = 1'b1;
        sel_idx   = j_idx;
      end
    end
  end

  // Next-state and output decode for the grant/run/capture sequence.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    gnt_nxt    = gnt;
    done_nxt   = '0;
    result_nxt = result;
    mpd_nxt    = mul_mpd;
    mpr_nxt    = mul_mpr;
    mul_enable = 1'b0;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_nxt        = RUN;
          gnt_nxt          = '0;
          gnt_nxt[sel_idx] = 1'b1;
          mpd_nxt          = mpd_in[sel_idx*WIDTH +: WIDTH];
          mpr_nxt          = mpr_in[sel_idx*WIDTH +: WIDTH];
          idx_nxt          = sel_idx;
          cnt_nxt          = '0;
          ptr_nxt          = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
        end
      end

      RUN: begin
        mul_enable = 1'b1;
        busy       = 1'b1;
        cnt_nxt    = cnt + 1'b1;
        if (cnt == LAST_CNT) state_nxt = DONE;
      end

      DONE: begin
        busy          = 1'b1;
        result_nxt    = mul_res;
        done_nxt[idx] = 1'b1;
        gnt_nxt       = '0;
        state_nxt     = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      idx     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      done    <= '0;
      result  <= '0;
      mul_mpd <= '0;
      mul_mpr <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      result  <= result_nxt;
      mul_mpd <= mpd_nxt;
      mul_mpr <= mpr_nxt;
    end
  end

endmodule

// File: tb/tb_booth_arbiter.sv
// Bench for booth_arbiter with a behavioural stand-in for the Booth
// multiplier. Expected completions are queued when a request is issued and
// matched against each done pulse.

module tb_booth_arbiter;

  localparam int W = 4;
  localparam int N = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*W-1:0]    mpd_in, mpr_in;
  logic [N-1:0]      gnt, done;
  logic [2*W-1:0]    result;
  logic              busy, mul_enable;
  logic [W-1:0]      mul_mpd, mul_mpr;
  logic [2*W-1:0]    mul_res = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  booth_arbiter #(.WIDTH(W), .N(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .mpd_in     (mpd_in),
    .mpr_in     (mpr_in),
    .gnt        (gnt),
    .done       (done),
    .result     (result),
    .busy       (busy),
    .mul_enable (mul_enable),
    .mul_mpd    (mul_mpd),
    .mul_mpr    (mul_mpr),
    .mul_res    (mul_res)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Multiplier stand-in: the product appears only on the 2W+2-th
  // consecutive enabled edge; any other enabled edge leaves junk behind.
  logic signed [2*W-1:0] prod;
  int m_cnt = 0;
  assign prod = $signed(mul_mpd) * $signed(mul_mpr);

  always @(posedge clock) begin
    if (!mul_enable) m_cnt <= 0;
    else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 2*W + 1) mul_res <= prod;
      else                  mul_res <= 8'hA5;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int             idx;
    logic [2*W-1:0] res;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int             idx;
    logic [W-1:0]   mpd;
    logic [W-1:0]   mpr;
    logic [2*W-1:0] res;
  } vec_t;

  // Scoreboard monitor: every done pulse must match the oldest queued
  // expectation, and each operation must hold gnt 11 and enable 10 cycles.
  int gnt_cnt = 0;
  int en_cnt  = 0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      gnt_cnt = 0;
      en_cnt  = 0;
    end else begin
      check("busy_vs_gnt", {31'd0, busy}, {31'd0, |gnt});
      check("gnt_onehot", {31'd0, $onehot0(gnt)}, 32'd1);
      if (done != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {28'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_idx", {28'd0, done}, {28'd0, N'(1) << e.idx});
          check("result", {24'd0, result}, {24'd0, e.res});
          check("gnt_cycles", gnt_cnt, 11);
          check("enable_cycles", en_cnt, 10);
        end
        gnt_cnt = 0;
        en_cnt  = 0;
      end
      if (gnt != '0) gnt_cnt++;
      if (mul_enable) en_cnt++;
    end
  end

  // Wait for done[idx]; optionally release req once granted, or disturb
  // operands and drop req in the middle of RUN. Returns the cycle seen.
  task automatic wait_done(input int idx, input bit drop_on_gnt, input bit perturb,
                           input int t0, output int at);
    at = -1;
    for (int k = 0; k < 60 && at < 0; k++) begin
      @(negedge clock);
      if (drop_on_gnt && gnt[idx]) req[idx] = 1'b0;
      if (perturb && cyc == t0 + 4) begin
        mpd_in[idx*W +: W] = ~mpd_in[idx*W +: W];
        mpr_in[idx*W +: W] = 4'h7;
        req[idx]           = 1'b0;
      end
      if (done[idx]) at = cyc;
    end
    check("done_seen", {31'd0, at >= 0}, 32'd1);
  endtask

  task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input bit perturb);
    int t0, at;
    exp_t e;
    @(negedge clock);
    mpd_in[idx*W +: W] = a;
    mpr_in[idx*W +: W] = b;
    req[idx]           = 1'b1;
    e.idx = idx;
    e.res = exp;
    sb.push_back(e);
    t0 = cyc;
    wait_done(idx, !perturb, perturb, t0, at);
    check("latency", at - t0, 12);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    {28'd0, gnt}, 32'd0);
    check({tag, "_done"},   {28'd0, done}, 32'd0);
    check({tag, "_result"}, {24'd0, result}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy}, 32'd0);
    check({tag, "_enable"}, {31'd0, mul_enable}, 32'd0);
    check({tag, "_mpd"},    {28'd0, mul_mpd}, 32'd0);
    check({tag, "_mpr"},    {28'd0, mul_mpr}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int   t0, at, n;
    bit   first0;
    logic [N-1:0] seen;
    exp_t e;

    vecs[0] = '{0, 4'h3, 4'hE, 8'hFA};  //  3 * -2 = -6
    vecs[1] = '{1, 4'h7, 4'h7, 8'h31};  //  7 *  7 = 49
    vecs[2] = '{2, 4'hB, 4'h3, 8'hF1};  // -5 *  3 = -15
    vecs[3] = '{3, 4'h0, 4'h9, 8'h00};  //  0 * -7 = 0
    vecs[0+4] = '{0, 4'hF, 4'hF, 8'h01};  // -1 * -1 = 1
    vecs[5] = '{1, 4'h8, 4'h8, 8'h40};  // -8 * -8 = 64
    vecs[6] = '{2, 4'h8, 4'h7, 8'hC8};  // -8 *  7 = -56

    reset  = 1'b1;
    req    = '0;
    mpd_in = '0;
    mpr_in = '0;
    #3;
    check_reset_outputs("por");
    @(negedge clock);
    reset = 1'b0;

    // Single operations across requesters and product corners.
    for (int v = 0; v < 7; v++)
      run_op(vecs[v].idx, vecs[v].mpd, vecs[v].mpr, vecs[v].res, 1'b0);

    // Requester 2 holds req through done: masked in the done cycle,
    // re-granted on the following edge.
    @(negedge clock);
    mpd_in[2*W +: W] = 4'h2;
    mpr_in[2*W +: W] = 4'hD;
    req[2]           = 1'b1;
    e.idx = 2;
    e.res = 8'hFA;
    sb.push_back(e);
    sb.push_back(e);
    t0 = cyc;
    wait_done(2, 1'b0, 1'b0, t0, at);
    check("mask_first_latency", at - t0, 12);
    @(negedge clock);
    check("mask_no_regrant", {28'd0, gnt}, 32'd0);
    @(negedge clock);
    check("mask_regrant", {28'd0, gnt}, 32'h4);
    req[2] = 1'b0;
    wait_done(2, 1'b0, 1'b0, t0, at);
    check("mask_second_latency", at - t0, 25);

    // Operands and req disturbed during RUN: latched values must win.
    run_op(1, 4'h6, 4'hD, 8'hEE, 1'b1);

    // Reset in cycle 5 of an operation.
    @(negedge clock);
    mpd_in[3*W +: W] = 4'h5;
    mpr_in[3*W +: W] = 4'h5;
    req[3]           = 1'b1;
    t0 = cyc;
    while (cyc < t0 + 5) @(negedge clock);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset  = 1'b1;
    req[3] = 1'b0;
    #1;
    check_reset_outputs("midrun");
    @(negedge clock);
    reset = 1'b0;
    seen  = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      seen |= done;
    end
    check("no_done_after_reset", {28'd0, seen}, 32'd0);

    // All four requesting: grants 0,1,2,3,0 with done every 12 cycles.
    @(negedge clock);
    mpd_in[0*W +: W] = 4'h2;  mpr_in[0*W +: W] = 4'h3;   //  2 *  3 = 6
    mpd_in[1*W +: W] = 4'hC;  mpr_in[1*W +: W] = 4'h5;   // -4 *  5 = -20
    mpd_in[2*W +: W] = 4'h7;  mpr_in[2*W +: W] = 4'h8;   //  7 * -8 = -56
    mpd_in[3*W +: W] = 4'hD;  mpr_in[3*W +: W] = 4'hD;   // -3 * -3 = 9
    req = '1;
    e.idx = 0; e.res = 8'h06; sb.push_back(e);
    e.idx = 1; e.res = 8'hEC; sb.push_back(e);
    e.idx = 2; e.res = 8'hC8; sb.push_back(e);
    e.idx = 3; e.res = 8'h09; sb.push_back(e);
    e.idx = 0; e.res = 8'h06; sb.push_back(e);
    t0     = cyc;
    n      = 0;
    first0 = 1'b1;
    for (int k = 0; k < 120 && n < 5; k++) begin
      @(negedge clock);
      if (done != '0) begin
        check("rr_spacing", cyc - t0, 12 * (n + 1));
        if (done[0] && first0) first0 = 1'b0;
        else                   req = req & ~done;
        n++;
      end
    end
    check("rr_done_count", n, 5);
    req = '0;

    repeat (4) @(negedge clock);
    check("final_busy", {31'd0, busy}, 32'd0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
